// File: rtl/red_pitaya_trigger_arbiter.sv
// Round-robin arbiter sharing one trigger block between NREQ consumers.
// Optional WAIT timeout with sticky per-requester flags: TRIGGER_ARBITER_TIMEOUT_EN.
module red_pitaya_trigger_arbiter #(
  parameter int NREQ = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] grant_o,
  output logic [NREQ-1:0] trig_o,
  output logic            rearm_o,
  input  logic            trig_i,
  input  logic [15:0]     addr,
  input  logic            wen,
  input  logic            ren,
  output logic            ack,
  output logic [31:0]     rdata,
  input  logic [31:0]     wdata
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, WAIT = 2'd2, HOLDOFF = 2'd3} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   ptr, ptr_n, g, g_n, pick, idx;
  logic            found;
  logic            enable;
  logic [31:0]     holdoff, hcnt, hcnt_n, event_cnt;
  logic [15:0]     cancel_cnt;
  logic            fire, cancel, timed_out;
  logic [31:0]     rd_mux;

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Scan downward so the lowest offset from ptr is the last (winning) hit.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (req_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_n = state;
    g_n     = g;
    ptr_n   = ptr;
    hcnt_n  = hcnt;
    fire    = 1'b0;
    cancel  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && found) begin
          g_n     = pick;
          ptr_n   = PW'((int'(pick) + 1) % NREQ);
          state_n = ARM;
        end
      end
      ARM: state_n = WAIT;
      WAIT: begin
        if (trig_i) begin
          fire    = 1'b1;
          hcnt_n  = holdoff;
          state_n = HOLDOFF;
        end else if (!req_i[g] || !enable) begin
          cancel  = 1'b1;
          state_n = IDLE;
        end else if (timed_out) begin
          state_n = IDLE;
        end
      end
      HOLDOFF: begin
        if (hcnt == '0) state_n = IDLE;
        else            hcnt_n  = hcnt - 32'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from next-state so they line up with the state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      g       <= '0;
      ptr     <= '0;
      hcnt    <= '0;
      grant_o <= '0;
      trig_o  <= '0;
      rearm_o <= 1'b0;
    end else begin
      state   <= state_n;
      g       <= g_n;
      ptr     <= ptr_n;
      hcnt    <= hcnt_n;
      grant_o <= (state_n == IDLE) ? '0 : onehot(g_n);
      trig_o  <= fire ? onehot(g) : '0;
      rearm_o <= (state_n == ARM);
    end
  end

`ifdef TRIGGER_ARBITER_TIMEOUT_EN
  logic [31:0]     timeout, wait_cnt;
  logic [NREQ-1:0] sticky, sticky_set, sticky_clr;

  assign timed_out  = (timeout != '0) && (wait_cnt == timeout - 32'd1);
  // Leaving WAIT for IDLE without a cancel can only be the timeout path.
  assign sticky_set = (state == WAIT && state_n == IDLE && !cancel) ? onehot(g) : '0;
  assign sticky_clr = (wen && addr == 16'h118) ? wdata[NREQ-1:0] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timeout  <= '0;
      wait_cnt <= '0;
      sticky   <= '0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + 32'd1 : '0;
      sticky   <= (sticky & ~sticky_clr) | sticky_set;
      if (wen && addr == 16'h114) timeout <= wdata;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (addr)
      16'h100: rd_mux[0] = enable;
      16'h104: rd_mux = holdoff;
      16'h108: begin
        rd_mux[8 +: NREQ] = grant_o;
        rd_mux[1:0]       = state;
      end
      16'h10C: rd_mux = event_cnt;
      16'h110: rd_mux[15:0] = cancel_cnt;
`ifdef TRIGGER_ARBITER_TIMEOUT_EN
      16'h114: rd_mux = timeout;
      16'h118: rd_mux[NREQ-1:0] = sticky;
`endif
      default: rd_mux = '0;
    endcase
  end

  // A clearing write in the same cycle as an increment wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable     <= 1'b0;
      holdoff    <= '0;
      event_cnt  <= '0;
      cancel_cnt <= '0;
      ack        <= 1'b0;
      rdata      <= '0;
    end else begin
      ack   <= wen | ren;
      rdata <= ren ? rd_mux : '0;
      if (fire) event_cnt <= event_cnt + 32'd1;
      if (cancel && cancel_cnt != 16'hFFFF) cancel_cnt <= cancel_cnt + 16'd1;
      if (wen) begin
        case (addr)
          16'h100: enable     <= wdata[0];
          16'h104: holdoff    <= wdata;
          16'h10C: event_cnt  <= '0;
          16'h110: cancel_cnt <= '0;
          default: ;
        endcase
      end
    end
  end

endmodule
